// File: rtl/raster_pkg.sv
// ============================================================================
// Module  : raster_pkg
// Brief   : Shared types and width helpers for the scanline span setup block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package raster_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DIV   = 3'd2,
        ST_MUL   = 3'd3,
        ST_SUM   = 3'd4,
        ST_OUT   = 3'd5
    } span_state_e;

    // Source of the interpolation factor, fixed during SETUP.
    typedef enum logic [1:0] {
        T_QUOT = 2'd0,
        T_ZERO = 2'd1,
        T_ONE  = 2'd2
    } tsel_e;

    // Result fields are sized for the widest supported pixel x.
    localparam int SPAN_X_MAX_W = 16;

    typedef struct packed {
        logic [SPAN_X_MAX_W-1:0] start_x;
        logic [SPAN_X_MAX_W-1:0] end_x;
        logic                    empty;
    } span_result_t;

    function automatic int prod_width(input int coord_w, input int frac_w);
        return coord_w + 1 + frac_w + 1;
    endfunction

    function automatic int sum_width(input int coord_w);
        return coord_w + 2;
    endfunction

    localparam int PROD_W_DEF = prod_width(16, 14);
    localparam int SUM_W_DEF  = sum_width(16);

endpackage

`default_nettype wire

// File: rtl/span_div.sv
// ============================================================================
// Module  : span_div
// Brief   : Unsigned restoring divider, quot = floor(num * 2^FRAC_W / den),
//           one quotient bit per cycle, done FRAC_W+1 cycles after start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module span_div #(
    parameter int WIDTH  = 17,
    parameter int FRAC_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  num_mag,
    input  logic [WIDTH-1:0]  den_mag,
    output logic [FRAC_W:0]   quot,
    output logic              done
);

    localparam int CW = $clog2(FRAC_W + 1);

    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  den_q, den_use;
    logic [WIDTH:0]    rem_in;
    logic [FRAC_W:0]   quot_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              ge;

    // The load cycle already resolves the integer quotient bit.
    always_comb begin
        den_use = start ? den_mag : den_q;
        rem_in  = start ? {1'b0, num_mag} : {rem_q, 1'b0};
        ge      = (rem_in >= {1'b0, den_use});
        rem_d   = ge ? WIDTH'(rem_in - {1'b0, den_use}) : rem_in[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                den_q  <= den_mag;
                quot_q <= {{FRAC_W{1'b0}}, ge};
                cnt_q  <= CW'(FRAC_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_d;
                quot_q <= {quot_q[FRAC_W-1:0], ge};
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quot = quot_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/scanline_span.sv
// ============================================================================
// Module  : scanline_span
// Brief   : Interpolates two polygon edges at a scanline and emits an ordered,
//           screen-clipped pixel span with fixed latency over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scanline_span
    import raster_pkg::*;
#(
    parameter int COORD_W  = 16,
    parameter int SUBPIX   = 5,
    parameter int FRAC_W   = 14,
    parameter int X_W      = 11,
    parameter int SCREEN_W = 640
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] y,
    input  logic signed [COORD_W-1:0] ax,
    input  logic signed [COORD_W-1:0] ay,
    input  logic signed [COORD_W-1:0] bx,
    input  logic signed [COORD_W-1:0] by,
    input  logic signed [COORD_W-1:0] cx,
    input  logic signed [COORD_W-1:0] cy,
    input  logic signed [COORD_W-1:0] dx,
    input  logic signed [COORD_W-1:0] dy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [X_W-1:0]            start_x,
    output logic [X_W-1:0]            end_x,
    output logic                      out_empty
);

    localparam int DW = COORD_W + 1;
    localparam int TW = FRAC_W + 1;
    localparam int PW = prod_width(COORD_W, FRAC_W);
    localparam int SW = sum_width(COORD_W);
    localparam logic [TW-1:0]        T_UNITY = {1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [SW-1:0] SCR_MAX = SW'(SCREEN_W - 1);

    span_state_e state_q, state_d;
    logic        ready_q;
    logic        accept;
    logic        div_start;

    logic signed [COORD_W-1:0] y_q;
    logic signed [COORD_W-1:0] p0x_q [2];
    logic signed [COORD_W-1:0] p0y_q [2];
    logic signed [COORD_W-1:0] p1x_q [2];
    logic signed [COORD_W-1:0] p1y_q [2];

    tsel_e                tsel_q [2];
    tsel_e                tsel_w [2];
    logic signed [PW-1:0] prod_q [2];
    logic signed [PW-1:0] prod_w [2];
    logic signed [SW-1:0] x_w    [2];
    logic [1:0]           done_w;

    logic signed [DW-1:0] ty;
    logic signed [SW-1:0] x_lo, x_hi, lo, hi, clip_lo, clip_hi;
    span_result_t         result_q, result_d;

    assign accept    = in_valid && ready_q;
    assign div_start = (state_q == ST_SETUP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_DIV;
            ST_DIV:   if (&done_w) state_d = ST_MUL;
            ST_MUL:   state_d = ST_SUM;
            ST_SUM:   state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ty = {y_q[COORD_W-1], y_q};
        ty = ty <<< SUBPIX;
    end

    for (genvar e = 0; e < 2; e++) begin : g_edge
        logic signed [DW-1:0] num, den, dxe;
        logic [DW-1:0]        num_mag, den_mag;
        logic [TW-1:0]        quot, t;
        logic signed [PW-1:0] prod;
        logic [PW-1:0]        prod_mag, delta_mag;
        logic signed [SW-1:0] delta, x;
        logic                 div_done;
        tsel_e                tsel;

        always_comb begin
            num     = ty - {p0y_q[e][COORD_W-1], p0y_q[e]};
            den     = {p1y_q[e][COORD_W-1], p1y_q[e]} - {p0y_q[e][COORD_W-1], p0y_q[e]};
            dxe     = {p1x_q[e][COORD_W-1], p1x_q[e]} - {p0x_q[e][COORD_W-1], p0x_q[e]};
            num_mag = num[DW-1] ? $unsigned(-num) : $unsigned(num);
            den_mag = den[DW-1] ? $unsigned(-den) : $unsigned(den);

            tsel = T_QUOT;
            if (den == '0)
                tsel = T_ONE;
            else if (num != '0 && num[DW-1] != den[DW-1])
                tsel = T_ZERO;
            else if (num_mag >= den_mag)
                tsel = T_ONE;

            t = quot;
            if (tsel_q[e] == T_ONE)
                t = T_UNITY;
            else if (tsel_q[e] == T_ZERO)
                t = '0;
            prod = {{(PW-DW){dxe[DW-1]}}, dxe} * $signed({{(PW-TW){1'b0}}, t});

            // Shift the magnitude so the fractional part truncates toward zero.
            prod_mag  = prod_q[e][PW-1] ? $unsigned(-prod_q[e]) : $unsigned(prod_q[e]);
            delta_mag = prod_mag >> FRAC_W;
            delta     = prod_q[e][PW-1] ? -$signed(SW'(delta_mag)) : $signed(SW'(delta_mag));
            x         = {{2{p0x_q[e][COORD_W-1]}}, p0x_q[e]} + delta;
        end

        span_div #(
            .WIDTH  (DW),
            .FRAC_W (FRAC_W)
        ) u_div (
            .clk     (clk),
            .reset   (reset),
            .start   (div_start),
            .num_mag (num_mag),
            .den_mag (den_mag),
            .quot    (quot),
            .done    (div_done)
        );

        assign tsel_w[e] = tsel;
        assign prod_w[e] = prod;
        assign x_w[e]    = x;
        assign done_w[e] = div_done;
    end

    always_comb begin
        x_lo     = (x_w[0] < x_w[1]) ? x_w[0] : x_w[1];
        x_hi     = (x_w[0] < x_w[1]) ? x_w[1] : x_w[0];
        lo       = x_lo >>> SUBPIX;
        hi       = x_hi >>> SUBPIX;
        clip_lo  = (lo < 0) ? '0 : lo;
        clip_hi  = (hi > SCR_MAX) ? SCR_MAX : hi;
        result_d = '0;
        if (hi < 0 || lo > SCR_MAX) begin
            result_d.empty = 1'b1;
        end else begin
            result_d.start_x = SPAN_X_MAX_W'(clip_lo);
            result_d.end_x   = SPAN_X_MAX_W'(clip_hi);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
            y_q      <= '0;
            for (int e = 0; e < 2; e++) begin
                p0x_q[e]  <= '0;
                p0y_q[e]  <= '0;
                p1x_q[e]  <= '0;
                p1y_q[e]  <= '0;
                tsel_q[e] <= T_QUOT;
                prod_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                y_q      <= y;
                p0x_q[0] <= ax;
                p0y_q[0] <= ay;
                p1x_q[0] <= bx;
                p1y_q[0] <= by;
                p0x_q[1] <= cx;
                p0y_q[1] <= cy;
                p1x_q[1] <= dx;
                p1y_q[1] <= dy;
            end
            for (int e = 0; e < 2; e++) begin
                if (state_q == ST_SETUP) tsel_q[e] <= tsel_w[e];
                if (state_q == ST_MUL)   prod_q[e] <= prod_w[e];
            end
            if (state_q == ST_SUM) result_q <= result_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q == ST_OUT);
    assign start_x   = X_W'(result_q.start_x);
    assign end_x     = X_W'(result_q.end_x);
    assign out_empty = result_q.empty;

endmodule

`default_nettype wire

// File: tb/tb_scanline_span.sv
// ============================================================================
// Module  : tb_scanline_span
// Brief   : Directed self-checking bench for scanline_span at default sizes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scanline_span;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_empty;
    logic signed [15:0] y, ax, ay, bx, by, cx, cy, dx, dy;
    logic [10:0] start_x, end_x;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scanline_span dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .cx        (cx),
        .cy        (cy),
        .dx        (dx),
        .dy        (dy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .start_x   (start_x),
        .end_x     (end_x),
        .out_empty (out_empty)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic signed [15:0] yy, iax, iay, ibx, iby, icx, icy, idx, idy);
        y = yy; ax = iax; ay = iay; bx = ibx; by = iby;
        cx = icx; cy = icy; dx = idx; dy = idy;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd18);
    endtask

    task automatic run_req(input string tag,
                           input logic signed [15:0] yy, iax, iay, ibx, iby, icx, icy, idx, idy,
                           input int es, input int ee, input int eem);
        drive(yy, iax, iay, ibx, iby, icx, icy, idx, idy);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_ready(tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(16'sd7, 16'sd1234, -16'sd99, 16'sd4321, 16'sd55, -16'sd800, 16'sd3, 16'sd9, -16'sd17);
        wait_valid(tag);
        chk({tag, " start_x"}, 32'(start_x), 32'(es));
        chk({tag, " end_x"}, 32'(end_x), 32'(ee));
        chk({tag, " empty"}, 32'(out_empty), 32'(eem));
        @(posedge clk); #1;
        chk({tag, " post valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset start_x", 32'(start_x), 32'd0);
        chk("reset end_x", 32'(end_x), 32'd0);
        chk("reset empty", 32'(out_empty), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after reset in_ready", 32'(in_ready), 32'd1);

        run_req("basic",     10, 0, 0, 640, 640, 1280, 0, 1280, 640, 10, 40, 0);
        run_req("swap",      10, 1280, 0, 1280, 640, 0, 0, 640, 640, 10, 40, 0);
        run_req("reversed",  10, 640, 640, 0, 0, 1280, 0, 1280, 640, 10, 40, 0);
        run_req("horiz",     10, 0, 320, 960, 320, 1280, 0, 1280, 640, 30, 40, 0);
        run_req("clamp1",    30, 0, 0, 640, 640, 1280, 0, 1280, 640, 20, 40, 0);
        run_req("neg_y",     -5, 96, 0, 640, 640, 1280, 0, 1280, 640, 3, 40, 0);
        run_req("trunc",     1, 97, 0, -3, 96, 1280, 0, 1280, 640, 2, 40, 0);
        run_req("clip_both", 0, 0, 0, -320, 0, 0, 0, 30000, 0, 0, 639, 0);
        run_req("edge_639",  0, 0, 0, 20479, 0, 0, 0, 31, 0, 0, 639, 0);
        run_req("last_px",   0, 0, 0, 20470, 0, 0, 0, 20479, 0, 639, 639, 0);
        run_req("off_right", 0, 0, 0, 20480, 0, 0, 0, 25000, 0, 0, 0, 1);
        run_req("off_left",  0, 0, 0, -100, 0, 0, 0, -33, 0, 0, 0, 1);
        run_req("first_px",  0, 0, 0, -1, 0, 0, 0, 5, 0, 0, 0, 0);

        // Backpressure: result held while a competing request is presented.
        drive(10, 0, 0, 640, 640, 1280, 0, 1280, 640);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_ready("bp");
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            drive(20, 0, 0, 0, 0, 5000, 0, 5000, 0);
            @(posedge clk); #1;
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
            chk("bp hold start_x", 32'(start_x), 32'd10);
            chk("bp hold end_x", 32'(end_x), 32'd40);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp no stray result", 32'(seen), 32'd0);

        // Reset in the middle of the divide phase.
        drive(10, 0, 0, 640, 640, 1280, 0, 1280, 640);
        in_valid = 1'b1;
        wait_ready("rst");
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready low", 32'(in_ready), 32'd0);
        chk("rst out_valid low", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst in_ready back", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst aborted", 32'(seen), 32'd0);
        run_req("after_rst", 10, 0, 0, 640, 640, 1280, 0, 1280, 640, 10, 40, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scanline_span.md
Name: scanline_span

Overview:
- Parametrised next-generation scanline span setup for the triangle rasteriser.
- Per scanline, takes two polygon edges in signed subpixel fixed point and interpolates each edge's x at the scanline's y.
- Outputs an ordered, screen-clipped pixel span {start_x, end_x} to the span filler/bresenham stage over valid/ready.
- Generalises coordinate width, subpixel and fraction precision, and screen width; adds clipping, an empty-span flag, backpressure and fixed latency.

Parameters:
- COORD_W, 16: signed vertex coordinate width, two's complement, subpixel units.
- SUBPIX, 5: subpixel fraction bits (pixel = coord >>> SUBPIX).
- FRAC_W, 14: fraction bits of the interpolation factor t.
- X_W, 11: output pixel x width.
- SCREEN_W, 640: visible width; legal x is 0..SCREEN_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block idle, request accepted when in_valid&in_ready
- y  in  COORD_W  scanline, integer pixels
- ax, ay, bx, by  in  COORD_W each  edge 1 endpoints, signed subpixel
- cx, cy, dx, dy  in  COORD_W each  edge 2 endpoints, signed subpixel
- out_valid  out  1  span result valid
- out_ready  in  1  downstream accepts result
- start_x, end_x  out  X_W each  clipped span, start_x<=end_x
- out_empty  out  1  span lies wholly off-screen

Behaviour:
- Reset, synchronous: state IDLE, in_ready=0 during the reset cycle and 1 after, out_valid=0, start_x=end_x=0, out_empty=0.
- reset asserted mid-operation aborts the request with no output.
- Inputs are registered on accept. Later input changes do not affect the result.
- FSM states and transitions:
  - IDLE: in_ready=1, go to SETUP on accept.
  - SETUP: 1 cycle. Compute ty=y<<<SUBPIX. Per edge, compute num=ty-p0y and den=p1y-p0y, both COORD_W+1 signed.
  - DIV: exactly FRAC_W+1 cycles. Both dividers run in parallel.
  - MUL: 1 cycle.
  - SUM: 1 cycle.
  - OUT: hold out_valid=1 and all outputs stable until out_ready=1, then go to IDLE.
- out_valid rises exactly FRAC_W+4 clock edges after the accept edge (18 at defaults), independent of operand values.
- Interpolation factor t, unsigned Q1.FRAC_W, selected in priority order:
  - den==0 (horizontal edge): t=1.0, so x=p1x.
  - num and den have opposite signs and num!=0: t=0, so x=p0x.
  - |num|>=|den|: t=1.0.
  - Otherwise t = floor(|num|*2^FRAC_W / |den|).
  - Clamped cases still consume the full DIV time.
- Edge x: x = p0x + trunc_toward_zero(((p1x-p0x)*t) >> FRAC_W).
  - Product width is COORD_W+1+FRAC_W+1 signed.
  - Shift the magnitude, then restore the sign.
  - Sum width is COORD_W+2 signed. No wrap is permitted.
- Span: lo=min(x1,x2)>>>SUBPIX and hi=max(x1,x2)>>>SUBPIX (arithmetic shift, floor). Edge order is irrelevant.
- Clipping:
  - If hi<0 or lo>=SCREEN_W: out_empty=1, start_x=end_x=0.
  - Otherwise: start_x=max(lo,0), end_x=min(hi,SCREEN_W-1), out_empty=0.
- A single request is in flight at a time. in_valid while busy is ignored (in_ready=0).
- After out_valid&out_ready, in_ready is 1 on the next cycle.

Decomposition:
- Shared package raster_pkg holds:
  - the span FSM state typedef;
  - a span result struct {start_x, end_x, empty};
  - localparams for product and sum widths derived from COORD_W and FRAC_W.
- Sub-module span_div: unsigned restoring divider.
  - Parameters: width, FRAC_W.
  - Ports: clk, reset, start, num_mag, den_mag, quot, done.
  - done is asserted exactly FRAC_W+1 cycles after start.
  - Two instances, one per edge.

Test Plan:
- Basic span: ax,ay=0,0; bx,by=640,640; cx,cy=1280,0; dx,dy=1280,640; y=10.
  - Expect t1=0.5; start_x=10, end_x=40, out_empty=0.
  - out_valid exactly 18 edges after accept.
- Swapped edges: same request with edge1 and edge2 swapped, and a second case with a/b reversed.
  - Expect start_x=10, end_x=40 in both.
- Degenerate and out-of-range cases:
  - Horizontal edge ay=by=320, bx=960: x1 pixel 30.
  - y=30 on the 0..640 edge: t clamps to 1.0, pixel 20.
  - y=-5: t=0, x=ax.
- Clipping:
  - x1=-320 and x2=30000 (subpixel): start_x=0, end_x=639.
  - Both edges at x>=20480: out_empty=1, start_x=end_x=0.
- Backpressure and protocol:
  - Hold out_ready=0 for 10 cycles: outputs stable and in_ready=0 throughout.
  - A new in_valid during that time is not accepted.
  - Release out_ready: in_ready=1 next cycle.
- Reset mid-DIV:
  - Assert reset in cycle 5 after accept: out_valid never asserts for that request.
  - in_ready=1 the cycle after reset deasserts.
  - Next request produces a correct result.
